cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Arbiter for the single common data bus (CDB) shared by the ALU and the load buffer. Each producer writes completed results (ROB tag + value) into its own small FIFO. A round-robin arbiter broadcasts at most one result per cycle to the RS, ROB and load buffer. The block sits between the execution units and every CDB consumer, and is flushed by the ROB on misprediction.

## Interface
- `DEPTH`, 4: entries per source FIFO, power of two, at least 2.
- `clk_in`  in  1  clock; all state changes on the rising edge.
- `rst_in`  in  1  asynchronous reset, active-high.
- `rdy_in`  in  1  global enable; when low, all state holds and inputs are ignored.
- `rob_cdb_rst_in`  in  1  synchronous flush, effective only when `rdy_in` is high.
- `alu_cdb_en_in`  in  1  ALU result valid.
- `alu_cdb_b_in`  in  `ROBWidth`  ALU result ROB tag; 0 is illegal when `en` is high.
- `alu_cdb_result_in`  in  `IDWidth`  ALU result value.
- `cdb_alu_rdy_out`  out  1  ALU FIFO can accept a result this cycle.
- `lbuffer_cdb_en_in`  in  1  load result valid.
- `lbuffer_cdb_b_in`  in  `ROBWidth`  load result ROB tag.
- `lbuffer_cdb_result_in`  in  `IDWidth`  load result value.
- `cdb_lbuffer_rdy_out`  out  1  load FIFO can accept a result this cycle.
- `cdb_b_out`  out  `ROBWidth`  broadcast tag; 0 means no broadcast.
- `cdb_result_out`  out  `IDWidth`  broadcast value.
- `cdb_src_out`  out  1  source of the broadcast, `CDB_SRC_ALU`=0 or `CDB_SRC_LB`=1.

## Operation
- Push rule: a source is pushed when `rdy_in` is high, its `en` is high, its `rdy_out` is high and no flush is active.
  - `rdy_out` = (count != `DEPTH`). It is combinational from the count only, with no dependence on a same-cycle pop.
  - An `en` pulse while `rdy_out` is low is a producer protocol violation. The block drops that input and must not corrupt its state.
- Candidates: a source is a candidate when its FIFO is non-empty, using the FIFO head.
- Priority register `prio` (1 bit, reset 0 = ALU preferred).
  - Both sources are candidates: grant `prio` and set `prio` to the other source.
  - One source is a candidate: grant it and set `prio` to the other source.
  - No candidates: `prio` is unchanged.
- Grant: the granted entry is popped. `cdb_b_out`, `cdb_result_out` and `cdb_src_out` are registered from it.
- No grant: `cdb_b_out` <= 0, `cdb_result_out` <= 0, `cdb_src_out` <= 0. Every broadcast therefore lasts exactly one cycle.
- Push and pop on the same FIFO in the same cycle: count is unchanged and pointers advance mod `DEPTH`. This is legal even at count = `DEPTH`-1.
- Flush (`rob_cdb_rst_in` high and `rdy_in` high):
  - both FIFOs are emptied (pointers and counts to 0);
  - `prio` <= 0;
  - all outputs are registered to 0;
  - inputs presented that cycle are discarded.
- `rdy_in` low: FIFOs, `prio` and output registers hold. Consumers are gated by `rdy_in`, so a held output is not re-consumed.
- Reset: FIFOs are empty, `prio` = 0. `cdb_b_out`, `cdb_result_out` and `cdb_src_out` are all 0. Both `rdy_out` are 1.

## Timing
- Without bypass: an input pushed at edge k can be granted at the earliest at edge k+1. It is then visible on the bus during cycle k+1..k+2 (latency 2 edges).
- With bypass: see Configuration (latency 1 edge).
- Sustained throughput is one broadcast per cycle. With both sources saturated, grants strictly alternate.
- A FIFO never holds an entry for more than 2·`DEPTH` grant cycles (bounded by round-robin fairness).
- Async reset takes effect immediately regardless of `clk_in` or `rdy_in`. Reset mid-operation loses all queued results.

## Configuration
- `CDB_BYPASS_EN` defined:
  - a source whose FIFO is empty and whose push is valid this cycle becomes a candidate using its input;
  - if granted, the input goes directly to the output registers at the same edge and is not written to the FIFO;
  - if not granted, it is pushed normally.
- `CDB_BYPASS_EN` undefined: all results pass through the FIFO, with the fixed 2-edge latency.
- Arbitration, flush and reset behaviour are identical in both builds.

## Structure
- Shared header `constant.vh` provides:
  - existing `ROBWidth` and `IDWidth`;
  - new `CDB_SRC_ALU` (1'b0), `CDB_SRC_LB` (1'b1) and `CDBSrcWidth` (1).
- Sub-module `cdb_fifo`, instantiated twice. It is parameterised on `DEPTH`, holds the tag+value payload, takes a flush input, and exposes push/pop/head/count/full.
- Arbitration, bypass muxing and output registers live in `cdb_arbiter`.

## Test plan
- Single ALU push: tag 3, value 0x55 at edge 0. Without bypass, the bus shows tag 3 / 0x55 / src 0 after edge 1, then tag 0 after edge 2. With `CDB_BYPASS_EN`, it shows after edge 0.
- Contention: ALU pushes tags 1, 2 and LB pushes tags 5, 6 in back-to-back cycles. Broadcast order is 1, 5, 2, 6 with `cdb_src_out` 0, 1, 0, 1.
- Fill: 4 ALU pushes while LB is saturated with preference on LB. `cdb_alu_rdy_out` drops once count = 4. A fifth pushed `en` is dropped. All 4 tags appear exactly once.
- Flush: 3 entries queued, `rob_cdb_rst_in` pulsed for 1 cycle with a simultaneous ALU push. The next cycle shows tag 0, both `rdy_out` are 1, and no old or new tag ever broadcasts.
- Stall: `rdy_in` held low for 3 cycles with tag 7 on the bus and entries queued. Outputs and queue are unchanged and inputs are ignored. After `rdy_in` rises, broadcasting resumes in order.
- Async reset asserted mid-cycle with both FIFOs non-empty. Outputs go to 0 immediately without a clock edge, and `prio` = 0 afterwards (ALU wins the first contention).

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared widths, source encodings and the CDB payload layout for the CDB arbiter.
package cdb_arbiter_pkg;
   localparam int   ROBWidth    = 4;
   localparam int   IDWidth     = 32;
   localparam int   CDBSrcWidth = 1;
   localparam logic CDB_SRC_ALU = 1'b0;
   localparam logic CDB_SRC_LB  = 1'b1;
   localparam int   CDBEntryWidth = ROBWidth + IDWidth;

   typedef struct packed {
      logic [ROBWidth-1:0] tag;
      logic [IDWidth-1:0]  value;
   } cdb_entry_t;
endpackage

// File: rtl/cdb_fifo.sv
// Small per-producer result FIFO (tag + value) with synchronous flush.
module cdb_fifo
   import cdb_arbiter_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       flush_in,
   input  logic                       push_in,
   input  logic                       pop_in,
   input  logic [CDBEntryWidth-1:0]   data_in,
   output logic [CDBEntryWidth-1:0]   head_out,
   output logic [$clog2(DEPTH):0]     count_out,
   output logic                       full_out
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = 1;
   localparam logic [AW:0]   CNT_ONE  = 1;
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   logic [CDBEntryWidth-1:0] mem [DEPTH];
   logic [AW-1:0]            wr_ptr;
   logic [AW-1:0]            rd_ptr;
   logic [AW:0]              count;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_in) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop_in)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push_in, pop_in})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Payload storage needs no reset; occupancy is tracked by count alone.
   always_ff @(posedge clk_in) begin
      if (push_in && !flush_in) mem[wr_ptr] <= data_in;
   end

   assign head_out  = mem[rd_ptr];
   assign count_out = count;
   assign full_out  = (count == CNT_FULL);
endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter broadcasting ALU / load-buffer results on the single CDB.
// Optional same-cycle bypass of an empty FIFO is enabled by defining CDB_BYPASS_EN.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   input  logic                  rob_cdb_rst_in,
   input  logic                  alu_cdb_en_in,
   input  logic [ROBWidth-1:0]   alu_cdb_b_in,
   input  logic [IDWidth-1:0]    alu_cdb_result_in,
   output logic                  cdb_alu_rdy_out,
   input  logic                  lbuffer_cdb_en_in,
   input  logic [ROBWidth-1:0]   lbuffer_cdb_b_in,
   input  logic [IDWidth-1:0]    lbuffer_cdb_result_in,
   output logic                  cdb_lbuffer_rdy_out,
   output logic [ROBWidth-1:0]   cdb_b_out,
   output logic [IDWidth-1:0]    cdb_result_out,
   output logic                  cdb_src_out
);
   logic [CDBEntryWidth-1:0] alu_in, lb_in, alu_head, lb_head;
   logic [CDBEntryWidth-1:0] alu_data, lb_data, grant_data;
   logic [$clog2(DEPTH):0]   alu_count, lb_count;
   logic alu_full, lb_full, alu_empty, lb_empty;
   logic alu_push, lb_push, alu_byp, lb_byp, alu_cand, lb_cand;
   logic alu_fifo_push, lb_fifo_push, alu_pop, lb_pop;
   logic grant_vld, grant_src, alu_grant, lb_grant;
   logic flush, prio;

   assign flush  = rdy_in & rob_cdb_rst_in;
   assign alu_in = {alu_cdb_b_in, alu_cdb_result_in};
   assign lb_in  = {lbuffer_cdb_b_in, lbuffer_cdb_result_in};

   assign cdb_alu_rdy_out     = ~alu_full;
   assign cdb_lbuffer_rdy_out = ~lb_full;

   // An en pulse while full is silently dropped by the ~full term.
   assign alu_push  = rdy_in & ~rob_cdb_rst_in & alu_cdb_en_in & ~alu_full;
   assign lb_push   = rdy_in & ~rob_cdb_rst_in & lbuffer_cdb_en_in & ~lb_full;
   assign alu_empty = (alu_count == '0);
   assign lb_empty  = (lb_count == '0);

`ifdef CDB_BYPASS_EN
   assign alu_byp = alu_empty & alu_push;
   assign lb_byp  = lb_empty & lb_push;
`else
   assign alu_byp = 1'b0;
   assign lb_byp  = 1'b0;
`endif

   assign alu_cand = ~alu_empty | alu_byp;
   assign lb_cand  = ~lb_empty | lb_byp;
   assign alu_data = alu_empty ? alu_in : alu_head;
   assign lb_data  = lb_empty ? lb_in : lb_head;

   always_comb begin
      grant_vld = rdy_in & ~rob_cdb_rst_in & (alu_cand | lb_cand);
      if (alu_cand && lb_cand) grant_src = prio;
      else if (lb_cand)        grant_src = CDB_SRC_LB;
      else                     grant_src = CDB_SRC_ALU;
   end

   assign alu_grant  = grant_vld & (grant_src == CDB_SRC_ALU);
   assign lb_grant   = grant_vld & (grant_src == CDB_SRC_LB);
   assign grant_data = (grant_src == CDB_SRC_LB) ? lb_data : alu_data;

   // A bypassed result goes straight to the bus and never occupies the FIFO.
   assign alu_pop       = alu_grant & ~alu_empty;
   assign lb_pop        = lb_grant & ~lb_empty;
   assign alu_fifo_push = alu_push & ~(alu_grant & alu_byp);
   assign lb_fifo_push  = lb_push & ~(lb_grant & lb_byp);

   cdb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .flush_in  (flush),
      .push_in   (alu_fifo_push),
      .pop_in    (alu_pop),
      .data_in   (alu_in),
      .head_out  (alu_head),
      .count_out (alu_count),
      .full_out  (alu_full)
   );

   cdb_fifo #(.DEPTH(DEPTH)) u_lb_fifo (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .flush_in  (flush),
      .push_in   (lb_fifo_push),
      .pop_in    (lb_pop),
      .data_in   (lb_in),
      .head_out  (lb_head),
      .count_out (lb_count),
      .full_out  (lb_full)
   );

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         prio           <= CDB_SRC_ALU;
         cdb_b_out      <= '0;
         cdb_result_out <= '0;
         cdb_src_out    <= CDB_SRC_ALU;
      end else if (rdy_in) begin
         if (rob_cdb_rst_in) begin
            prio           <= CDB_SRC_ALU;
            cdb_b_out      <= '0;
            cdb_result_out <= '0;
            cdb_src_out    <= CDB_SRC_ALU;
         end else if (grant_vld) begin
            prio           <= ~grant_src;
            cdb_b_out      <= grant_data[CDBEntryWidth-1:IDWidth];
            cdb_result_out <= grant_data[IDWidth-1:0];
            cdb_src_out    <= grant_src;
         end else begin
            cdb_b_out      <= '0;
            cdb_result_out <= '0;
            cdb_src_out    <= CDB_SRC_ALU;
         end
      end
   end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: queue-based reference model plus directed scenarios.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   localparam int DEPTH = 4;
   localparam int EW    = ROBWidth + IDWidth;
   typedef logic [EW-1:0] ent_t;

   logic                clk_in = 1'b0;
   logic                rst_in = 1'b1;
   logic                rdy_in = 1'b1;
   logic                rob_cdb_rst_in = 1'b0;
   logic                alu_cdb_en_in = 1'b0;
   logic [ROBWidth-1:0] alu_cdb_b_in = '0;
   logic [IDWidth-1:0]  alu_cdb_result_in = '0;
   logic                cdb_alu_rdy_out;
   logic                lbuffer_cdb_en_in = 1'b0;
   logic [ROBWidth-1:0] lbuffer_cdb_b_in = '0;
   logic [IDWidth-1:0]  lbuffer_cdb_result_in = '0;
   logic                cdb_lbuffer_rdy_out;
   logic [ROBWidth-1:0] cdb_b_out;
   logic [IDWidth-1:0]  cdb_result_out;
   logic                cdb_src_out;

   always #5 clk_in = ~clk_in;

   cdb_arbiter #(.DEPTH(DEPTH)) dut (
      .clk_in                (clk_in),
      .rst_in                (rst_in),
      .rdy_in                (rdy_in),
      .rob_cdb_rst_in        (rob_cdb_rst_in),
      .alu_cdb_en_in         (alu_cdb_en_in),
      .alu_cdb_b_in          (alu_cdb_b_in),
      .alu_cdb_result_in     (alu_cdb_result_in),
      .cdb_alu_rdy_out       (cdb_alu_rdy_out),
      .lbuffer_cdb_en_in     (lbuffer_cdb_en_in),
      .lbuffer_cdb_b_in      (lbuffer_cdb_b_in),
      .lbuffer_cdb_result_in (lbuffer_cdb_result_in),
      .cdb_lbuffer_rdy_out   (cdb_lbuffer_rdy_out),
      .cdb_b_out             (cdb_b_out),
      .cdb_result_out        (cdb_result_out),
      .cdb_src_out           (cdb_src_out)
   );

   int tests = 0;
   int fails = 0;

   // Reference model: one queue per producer, a preference bit, and the expected bus.
   ent_t                qa[$];
   ent_t                ql[$];
   logic                m_prio = 1'b0;
   logic [ROBWidth-1:0] exp_b = '0;
   logic [IDWidth-1:0]  exp_v = '0;
   logic                exp_s = 1'b0;
   bit                  stepped = 0;
   logic [4:0]          obs[$];
   bit                  saw_alu_full = 0;

   always @(posedge clk_in or posedge rst_in) begin
      bit   pa, pl, ba, bl, ca, cl, g;
      ent_t ia, il, ge;
      if (rst_in) begin
         qa.delete(); ql.delete();
         m_prio = 1'b0; exp_b = '0; exp_v = '0; exp_s = 1'b0; stepped = 0;
      end else if (rdy_in) begin
         stepped = 1;
         if (rob_cdb_rst_in) begin
            qa.delete(); ql.delete();
            m_prio = 1'b0; exp_b = '0; exp_v = '0; exp_s = 1'b0;
         end else begin
            pa = alu_cdb_en_in && (qa.size() != DEPTH);
            pl = lbuffer_cdb_en_in && (ql.size() != DEPTH);
            ia = {alu_cdb_b_in, alu_cdb_result_in};
            il = {lbuffer_cdb_b_in, lbuffer_cdb_result_in};
            ba = 0; bl = 0;
`ifdef CDB_BYPASS_EN
            ba = pa && (qa.size() == 0);
            bl = pl && (ql.size() == 0);
`endif
            ca = (qa.size() != 0) || ba;
            cl = (ql.size() != 0) || bl;
            g  = (ca && cl) ? m_prio : cl;
            if (ca || cl) begin
               if (g == 1'b0) begin
                  if (ba) begin ge = ia; pa = 0; end
                  else ge = qa.pop_front();
               end else begin
                  if (bl) begin ge = il; pl = 0; end
                  else ge = ql.pop_front();
               end
               exp_b = ge[EW-1:IDWidth]; exp_v = ge[IDWidth-1:0]; exp_s = g;
               m_prio = ~g;
            end else begin
               exp_b = '0; exp_v = '0; exp_s = 1'b0;
            end
            if (pa) qa.push_back(ia);
            if (pl) ql.push_back(il);
         end
      end
   end

   always @(negedge clk_in) begin
      tests++;
      if (cdb_b_out !== exp_b || cdb_result_out !== exp_v || cdb_src_out !== exp_s ||
          cdb_alu_rdy_out !== (qa.size() != DEPTH) || cdb_lbuffer_rdy_out !== (ql.size() != DEPTH)) begin
         fails++;
         $display("FAIL model_cmp t=%0t actual b=%0d v=%0h s=%0d ardy=%0d lrdy=%0d required b=%0d v=%0h s=%0d ardy=%0d lrdy=%0d",
                  $time, cdb_b_out, cdb_result_out, cdb_src_out, cdb_alu_rdy_out, cdb_lbuffer_rdy_out,
                  exp_b, exp_v, exp_s, qa.size() != DEPTH, ql.size() != DEPTH);
      end
      if (stepped && cdb_b_out != '0) obs.push_back({cdb_src_out, cdb_b_out});
      stepped = 0;
      if (!cdb_alu_rdy_out) saw_alu_full = 1;
   end

   task automatic chk(string name, int act, int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   function automatic int obs_tag(int i);
      return (i < obs.size()) ? int'(obs[i][3:0]) : -1;
   endfunction

   function automatic int obs_src(int i);
      return (i < obs.size()) ? int'(obs[i][4]) : -1;
   endfunction

   task automatic step(bit ae, int at, int av, bit le, int lt, int lv);
      alu_cdb_en_in         = ae;
      alu_cdb_b_in          = at[ROBWidth-1:0];
      alu_cdb_result_in     = av;
      lbuffer_cdb_en_in     = le;
      lbuffer_cdb_b_in      = lt[ROBWidth-1:0];
      lbuffer_cdb_result_in = lv;
      @(negedge clk_in);
   endtask

   task automatic idle(int n);
      repeat (n) step(0, 0, 0, 0, 0, 0);
   endtask

   task automatic flush_pulse();
      rob_cdb_rst_in = 1'b1;
      idle(1);
      rob_cdb_rst_in = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      int e_tag[4];
      int e_src[4];
      int f_tag[14];

      repeat (2) @(negedge clk_in);
      chk("reset_b", cdb_b_out, 0);
      chk("reset_ardy", cdb_alu_rdy_out, 1);
      chk("reset_lrdy", cdb_lbuffer_rdy_out, 1);
      rst_in = 1'b0;

      // single ALU push
      obs.delete();
      step(1, 3, 'h55, 0, 0, 0);
`ifndef CDB_BYPASS_EN
      chk("single_not_yet", cdb_b_out, 0);
      idle(1);
`endif
      chk("single_tag", cdb_b_out, 3);
      chk("single_val", cdb_result_out, 'h55);
      chk("single_src", cdb_src_out, 0);
      idle(1);
      chk("single_one_cycle", cdb_b_out, 0);
      idle(2);
      chk("single_count", obs.size(), 1);

      // contention
      flush_pulse();
      obs.delete();
      step(1, 1, 'h11, 1, 5, 'h50);
      step(1, 2, 'h22, 1, 6, 'h60);
      idle(5);
      e_tag = '{1, 5, 2, 6};
      e_src = '{0, 1, 0, 1};
      chk("cont_count", obs.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("cont_tag%0d", i), obs_tag(i), e_tag[i]);
         chk($sformatf("cont_src%0d", i), obs_src(i), e_src[i]);
      end

      // fill the ALU FIFO while the load buffer is saturated
      flush_pulse();
      obs.delete();
      saw_alu_full = 0;
      for (int i = 0; i < 8; i++) step(1, i + 1, i * 3, 1, i + 8, i);
      idle(10);
`ifndef CDB_BYPASS_EN
      chk("fill_rdy_dropped", int'(saw_alu_full), 1);
      f_tag = '{1, 8, 2, 9, 3, 10, 4, 11, 5, 12, 6, 13, 7, 15};
      chk("fill_count", obs.size(), 14);
      for (int i = 0; i < 14; i++) chk($sformatf("fill_tag%0d", i), obs_tag(i), f_tag[i]);
`endif

      // flush with three entries queued and a simultaneous ALU push
      obs.delete();
      step(1, 1, 'h1, 1, 5, 'h5);
      step(1, 2, 'h2, 1, 6, 'h6);
      rob_cdb_rst_in = 1'b1;
      step(1, 9, 'h9, 0, 0, 0);
      rob_cdb_rst_in = 1'b0;
      chk("flush_b", cdb_b_out, 0);
      chk("flush_ardy", cdb_alu_rdy_out, 1);
      chk("flush_lrdy", cdb_lbuffer_rdy_out, 1);
      n = obs.size();
`ifndef CDB_BYPASS_EN
      chk("flush_prior_bcast", n, 1);
`endif
      idle(6);
      chk("flush_no_later_bcast", obs.size(), n);

      // stall with rdy_in low
      flush_pulse();
      obs.delete();
      step(1, 7, 'h7, 1, 3, 'h3);
      step(1, 4, 'h4, 1, 6, 'h6);
      rdy_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(1, 13, 'hd, 1, 13, 'hd);
`ifndef CDB_BYPASS_EN
         chk($sformatf("stall_hold%0d", i), cdb_b_out, 7);
`endif
      end
      rdy_in = 1'b1;
      idle(6);
      e_tag = '{7, 3, 4, 6};
      chk("stall_count", obs.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("stall_tag%0d", i), obs_tag(i), e_tag[i]);
         chk($sformatf("stall_src%0d", i), obs_src(i), e_src[i]);
      end

      // async reset mid-cycle with both FIFOs occupied
      flush_pulse();
      step(1, 1, 'h1, 1, 5, 'h5);
      step(1, 2, 'h2, 1, 6, 'h6);
      alu_cdb_en_in = 1'b0;
      lbuffer_cdb_en_in = 1'b0;
      @(posedge clk_in);
      #2;
      rst_in = 1'b1;
      #1;
      chk("areset_b", cdb_b_out, 0);
      chk("areset_v", cdb_result_out, 0);
      chk("areset_s", cdb_src_out, 0);
      chk("areset_ardy", cdb_alu_rdy_out, 1);
      chk("areset_lrdy", cdb_lbuffer_rdy_out, 1);
      @(negedge clk_in);
      rst_in = 1'b0;
      obs.delete();
      step(1, 3, 'h3, 1, 9, 'h9);
      idle(4);
      chk("areset_count", obs.size(), 2);
      chk("areset_first_tag", obs_tag(0), 3);
      chk("areset_first_src", obs_src(0), 0);
      chk("areset_second_tag", obs_tag(1), 9);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
